// File: rtl/approx_pkg.sv
// -----------------------------------------------------------------------------
// approx_pkg -- ALU mode codes and Q-format defaults shared by controller and
// datapath.                                                           Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package approx_pkg;

  localparam logic [2:0] ADD_ONE  = 3'd0;
  localparam logic [2:0] SUB_ONE  = 3'd1;
  localparam logic [2:0] ADD_SUB  = 3'd2;
  localparam logic [2:0] MULTIPLY = 3'd3;
  localparam logic [2:0] ALU_IDLE = 3'd4;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 12;
  localparam int EPS_DEF    = 4;
  localparam int N_MAX_DEF  = 32;

  localparam logic [DATA_W_DEF-1:0] ONE_DEF = 16'h1000;

  typedef struct packed {
    logic x;
    logic y;
    logic x1;
    logic n;
  } alu_a_sel_t;

endpackage

`default_nettype wire

// File: rtl/approx_alu.sv
// -----------------------------------------------------------------------------
// approx_alu -- operand muxes, add/sub/multiply and signed saturation.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module approx_alu
  import approx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [2:0]               mode_i,
  input  alu_a_sel_t               a_sel_i,
  input  logic                     b_sel_i,
  input  logic                     sub_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic signed [DATA_W-1:0] x1_i,
  input  logic signed [DATA_W-1:0] x1_n_i,
  input  logic [7:0]               n_i,
  output logic signed [DATA_W-1:0] res_o
);

  // Two guard bits above the full product keep every intermediate exact.
  localparam int WW = 2*DATA_W + 2;
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [WW-1:0] ONE_W   = WW'(1) <<< FRAC_W;

  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic signed [WW-1:0]     a_w;
  logic signed [WW-1:0]     b_w;
  logic signed [WW-1:0]     wide;

  always_comb begin
    if (a_sel_i.x)       a = x_i;
    else if (a_sel_i.y)  a = y_i;
    else if (a_sel_i.x1) a = x1_i;
    else if (a_sel_i.n)  a = $signed({{(DATA_W-8){1'b0}}, n_i});
    else                 a = '0;

    b   = b_sel_i ? x1_n_i : '0;
    a_w = WW'(a);
    b_w = WW'(b);

    case (mode_i)
      ADD_ONE:  wide = a_w + WW'(1);
      SUB_ONE:  wide = a_w - ONE_W;
      ADD_SUB:  wide = sub_i ? (a_w - b_w) : (a_w + b_w);
      MULTIPLY: wide = (a_w * b_w) >>> FRAC_W;
      ALU_IDLE: wide = '0;
      default:  wide = '0;
    endcase

    if (wide > SAT_MAX)      res_o = SAT_MAX[DATA_W-1:0];
    else if (wide < SAT_MIN) res_o = SAT_MIN[DATA_W-1:0];
    else                     res_o = wide[DATA_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/approx_datapath.sv
// -----------------------------------------------------------------------------
// approx_datapath -- register file and termination logic for the Neumann-series
// reciprocal 1/x.                                                     Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module approx_datapath
  import approx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int EPS    = EPS_DEF,
  parameter int N_MAX  = N_MAX_DEF,
  parameter logic signed [DATA_W-1:0] X_MIN = 16'sh0800,
  parameter logic signed [DATA_W-1:0] X_MAX = 16'sh1800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [2:0]        mode_i,
  input  logic              x_to_alu_a_i,
  input  logic              y_to_alu_a_i,
  input  logic              x1_to_alu_a_i,
  input  logic              n_to_alu_a_i,
  input  logic              x1_n_to_alu_b_i,
  input  logic              sigma_n_to_alu_i,
  input  logic              wren_x1_i,
  input  logic              wren_x1_n_i,
  input  logic              wren_x1_n_mult_i,
  input  logic              wren_y_i,
  input  logic              wren_n_i,
  input  logic              wren_sigma_n_i,
  input  logic              check_for_termination_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic [7:0]        iter_o,
  output logic              err_o
);

  localparam logic signed [DATA_W-1:0] ONE_Q   = DATA_W'(1) <<< FRAC_W;
  localparam logic signed [DATA_W-1:0] EPS_Q   = DATA_W'(EPS);
  localparam logic signed [DATA_W-1:0] N_SAT_Q = DATA_W'(255);
  localparam logic [7:0]               N_MAX_Q = 8'(N_MAX);

  logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d, x1_q, x1_d, x1_n_q, x1_n_d;
  logic signed [DATA_W-1:0] alu_q, alu_res;
  logic [7:0]               n_q, n_d, n_sat, iter_q, iter_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     sigma_q, sigma_d, done_q, done_d;
  logic                     err_q, err_d, valid_q, valid_d, term;
  alu_a_sel_t               a_sel;

  assign a_sel = '{x: x_to_alu_a_i, y: y_to_alu_a_i, x1: x1_to_alu_a_i, n: n_to_alu_a_i};

  approx_alu #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_alu (
    .mode_i (mode_i),
    .a_sel_i(a_sel),
    .b_sel_i(x1_n_to_alu_b_i),
    .sub_i  (sigma_n_to_alu_i && sigma_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .x1_i   (x1_q),
    .x1_n_i (x1_n_q),
    .n_i    (n_q),
    .res_o  (alu_res)
  );

  assign n_sat = alu_q[DATA_W-1] ? 8'h00 : ((alu_q > N_SAT_Q) ? 8'hFF : alu_q[7:0]);
  assign term  = check_for_termination_i && !done_q &&
                 (((x1_n_q < EPS_Q) && (x1_n_q > -EPS_Q)) || (n_q > N_MAX_Q) || err_q);

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    x1_n_d   = x1_n_q;
    n_d      = n_q;
    sigma_d  = sigma_q;
    done_d   = done_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    result_d = result_q;
    iter_d   = iter_q;
    if (start_i) begin
      x_d     = $signed(x_i);
      y_d     = ONE_Q;
      n_d     = 8'd1;
      sigma_d = 1'b1;
      done_d  = 1'b0;
      err_d   = ($signed(x_i) < X_MIN) || ($signed(x_i) > X_MAX);
    end else if (!done_q) begin
      // Once done, the controller's trailing wren_y must not touch y.
      if (wren_x1_i)                       x1_d    = alu_q;
      if (wren_x1_n_i || wren_x1_n_mult_i) x1_n_d  = alu_q;
      if (wren_y_i)                        y_d     = alu_q;
      if (wren_n_i)                        n_d     = n_sat;
      if (wren_sigma_n_i)                  sigma_d = ~sigma_q;
      if (term) begin
        valid_d  = 1'b1;
        result_d = err_q ? '0 : y_q;
        iter_d   = n_q;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0; y_q <= '0; x1_q <= '0; x1_n_q <= '0; alu_q <= '0;
      n_q <= '0; sigma_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      valid_q <= 1'b0; result_q <= '0; iter_q <= '0;
    end else begin
      x_q <= x_d; y_q <= y_d; x1_q <= x1_d; x1_n_q <= x1_n_d; alu_q <= alu_res;
      n_q <= n_d; sigma_q <= sigma_d; done_q <= done_d; err_q <= err_d;
      valid_q <= valid_d; result_q <= result_d; iter_q <= iter_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign iter_o   = iter_q;
  assign err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_approx_datapath.sv
// -----------------------------------------------------------------------------
// tb_approx_datapath -- controller-sequenced scoreboard bench for two datapath
// instances (default N_MAX and N_MAX=4).                              Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_approx_datapath;
  import approx_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_i;
  logic [DW-1:0] x_i;
  logic [2:0]    mode_i;
  logic          xa, ya, x1a, na, x1nb, sig;
  logic          w_x1, w_x1n, w_mult, w_y, w_n, w_sig, chk;
  logic          va, vb, ea, eb;
  logic [DW-1:0] ra, rb;
  logic [7:0]    ia, ib;

  typedef struct packed {
    logic [15:0] res;
    logic [7:0]  iter;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic seen_valid;

  approx_datapath dut_a (
    .clk(clk), .rst(rst), .start_i(start_i), .x_i(x_i), .mode_i(mode_i),
    .x_to_alu_a_i(xa), .y_to_alu_a_i(ya), .x1_to_alu_a_i(x1a), .n_to_alu_a_i(na),
    .x1_n_to_alu_b_i(x1nb), .sigma_n_to_alu_i(sig),
    .wren_x1_i(w_x1), .wren_x1_n_i(w_x1n), .wren_x1_n_mult_i(w_mult),
    .wren_y_i(w_y), .wren_n_i(w_n), .wren_sigma_n_i(w_sig),
    .check_for_termination_i(chk),
    .valid_o(va), .result_o(ra), .iter_o(ia), .err_o(ea)
  );

  approx_datapath #(.N_MAX(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_i), .x_i(x_i), .mode_i(mode_i),
    .x_to_alu_a_i(xa), .y_to_alu_a_i(ya), .x1_to_alu_a_i(x1a), .n_to_alu_a_i(na),
    .x1_n_to_alu_b_i(x1nb), .sigma_n_to_alu_i(sig),
    .wren_x1_i(w_x1), .wren_x1_n_i(w_x1n), .wren_x1_n_mult_i(w_mult),
    .wren_y_i(w_y), .wren_n_i(w_n), .wren_sigma_n_i(w_sig),
    .check_for_termination_i(chk),
    .valid_o(vb), .result_o(rb), .iter_o(ib), .err_o(eb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input logic [7:0] iter, input logic err);
    exp_t e;
    e.res  = res;
    e.iter = iter;
    e.err  = err;
    return e;
  endfunction

  task automatic ctl_idle();
    mode_i = ALU_IDLE;
    xa = 0; ya = 0; x1a = 0; na = 0; x1nb = 0; sig = 0;
    w_x1 = 0; w_x1n = 0; w_mult = 0; w_y = 0; w_n = 0; w_sig = 0; chk = 0;
  endtask

  // One clock: outputs sampled on the falling edge, then the rising edge passes.
  task automatic step();
    exp_t e;
    @(negedge clk);
    seen_valid = va;
    if (va) begin
      check_eq("a_valid_expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_eq("a_result", ra, e.res);
        check_eq("a_iter", ia, e.iter);
        check_eq("a_err", ea, e.err);
      end
    end
    if (vb) begin
      check_eq("b_valid_expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_eq("b_result", rb, e.res);
        check_eq("b_iter", ib, e.iter);
        check_eq("b_err", eb, e.err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drives the controller's state sequence; follows dut_a's valid_o.
  task automatic run(input logic [15:0] x, input int abort_iter,
                     input exp_t exp_a, input exp_t exp_b, input logic push);
    logic term;
    term = 1'b0;
    if (push) begin
      qa.push_back(exp_a);
      qb.push_back(exp_b);
    end
    ctl_idle(); start_i = 1; x_i = x; step(); start_i = 0;
    mode_i = SUB_ONE; xa = 1; step(); ctl_idle();
    w_x1 = 1; w_x1n = 1; step(); ctl_idle();
    for (int it = 1; it <= 40 && !term; it++) begin
      mode_i = ADD_SUB; ya = 1; x1nb = 1; sig = 1; step(); ctl_idle();
      term = seen_valid;
      w_y = 1; mode_i = ADD_ONE; na = 1; step(); ctl_idle();
      if (!term) begin
        if (it == abort_iter) begin
          rst = 1; step(); rst = 0;
          return;
        end
        w_n = 1; w_sig = 1; mode_i = MULTIPLY; x1a = 1; x1nb = 1; step(); ctl_idle();
        w_mult = 1; step(); ctl_idle();
        chk = 1; step(); ctl_idle();
      end
    end
    if (push) check_eq("terminated", term, 1);
    step(); step();
    check_eq("qa_drained", qa.size(), 0);
    check_eq("qb_drained", qb.size(), 0);
  endtask

  initial begin
    rst = 1; start_i = 0; x_i = '0; ctl_idle();
    repeat (3) step();
    rst = 0; step();
    check_eq("rst_valid", va, 0);
    check_eq("rst_result", ra, 0);
    check_eq("rst_iter", ia, 0);
    check_eq("rst_err", ea, 0);

    run(16'h1000, 0, mk(16'h1000, 8'd2, 1'b0), mk(16'h1000, 8'd2, 1'b0), 1'b1);
    run(16'h0800, 0, mk(16'h1FFC, 8'd11, 1'b0), mk(16'h1F00, 8'd5, 1'b0), 1'b1);
    check_eq("a_y_after_late_wren", dut_a.y_q, 16'h1FFC);
    check_eq("b_y_after_late_wren", dut_b.y_q, 16'h1F00);
    run(16'h1800, 0, mk(16'h0AAC, 8'd11, 1'b0), mk(16'h0B00, 8'd5, 1'b0), 1'b1);
    run(16'h2400, 0, mk(16'h0000, 8'd2, 1'b1), mk(16'h0000, 8'd2, 1'b1), 1'b1);
    check_eq("err_held", ea, 1);
    run(16'h07FF, 0, mk(16'h0000, 8'd2, 1'b1), mk(16'h0000, 8'd2, 1'b1), 1'b1);
    run(16'h1000, 0, mk(16'h1000, 8'd2, 1'b0), mk(16'h1000, 8'd2, 1'b0), 1'b1);

    run(16'h0800, 3, mk(16'h0, 8'd0, 1'b0), mk(16'h0, 8'd0, 1'b0), 1'b0);
    check_eq("abort_valid", va, 0);
    check_eq("abort_result", ra, 0);
    check_eq("abort_iter", ia, 0);
    check_eq("abort_err", ea, 0);
    repeat (4) step();
    run(16'h1000, 0, mk(16'h1000, 8'd2, 1'b0), mk(16'h1000, 8'd2, 1'b0), 1'b1);

    ctl_idle(); start_i = 1; x_i = 16'h1000; step(); start_i = 0;
    mode_i = ADD_ONE; ya = 1; step(); ctl_idle();
    start_i = 1; x_i = 16'h1000; w_y = 1; w_n = 1; w_sig = 1; step();
    start_i = 0; ctl_idle();
    check_eq("start_prio_y", dut_a.y_q, 16'h1000);
    check_eq("start_prio_n", dut_a.n_q, 1);
    check_eq("start_prio_sigma", dut_a.sigma_q, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/approx_datapath.md
Name: approx_datapath

Overview:
- Datapath counterpart of the approximation controller.
- Receives the controller's ALU mode, register-transfer selects, write enables and termination-check strobe.
- Evaluates the reciprocal 1/x by Neumann series: y = Σ (−1)^n (x−1)^n, for x in [X_MIN, X_MAX].
- Returns a one-cycle valid_o pulse, which connects to the controller's valid_i, and holds the final result.

Parameters:
- DATA_W, 16, width of all signed fixed-point data registers.
- FRAC_W, 12, fractional bits (Q4.12 at defaults).
- EPS, 4, termination threshold in LSBs: stop when |x1_n| < EPS.
- N_MAX, 32, iteration cap: stop when n > N_MAX.
- X_MIN, 16'h0800, lowest legal x (0.5).
- X_MAX, 16'h1800, highest legal x (1.5).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  start pulse; same signal that drives the controller's start_i.
- x_i  in  DATA_W  operand x, sampled when start_i=1.
- mode_i  in  3  ALU operation: 0 ADD_ONE, 1 SUB_ONE, 2 ADD_SUB, 3 MULTIPLY, 4 ALU_IDLE.
- x_to_alu_a_i, y_to_alu_a_i, x1_to_alu_a_i, n_to_alu_a_i  in  1 each  ALU operand-A selects.
- x1_n_to_alu_b_i  in  1  ALU operand-B select.
- sigma_n_to_alu_i  in  1  apply the sigma register as the add/subtract sign.
- wren_x1_i, wren_x1_n_i, wren_x1_n_mult_i, wren_y_i, wren_n_i, wren_sigma_n_i  in  1 each  register write enables.
- check_for_termination_i  in  1  evaluate the termination condition this cycle.
- valid_o  out  1  one-cycle pulse: result ready.
- result_o  out  DATA_W  final y, held until the next termination.
- iter_o  out  8  value of n at termination.
- err_o  out  1  x_i was out of range on the last start.

Behaviour:
- Reset: all registers, valid_o, result_o, iter_o and err_o are 0; done=0.
- Start (start_i=1, any cycle):
  - x←x_i, y←1.0 (1<<FRAC_W), n←1, sigma←1 (subtract), done←0.
  - err_o←(x_i<X_MIN or x_i>X_MAX), signed compare.
  - Start has priority over every write enable in the same cycle.
- ALU (combinational):
  - A = x | y | x1 | n, chosen by first set select in that priority order; 0 if none set.
  - B = x1_n if x1_n_to_alu_b_i, else 0.
  - ADD_ONE: A+1. SUB_ONE: A−(1.0 in Q format).
  - ADD_SUB: A−B if (sigma_n_to_alu_i and sigma), else A+B.
  - MULTIPLY: (A·B) >>> FRAC_W, full 2·DATA_W product, arithmetic shift.
  - All results saturate to the signed DATA_W range.
  - ALU_IDLE or an undefined mode: result 0.
- alu_r register: loads the ALU result every cycle; write enables copy alu_r into targets one cycle later.
  - wren_x1→x1; wren_x1_n→x1_n; wren_x1_n_mult→x1_n; wren_y→y; wren_n→n; wren_sigma_n→sigma toggles.
  - Simultaneous enables all execute.
- Per-iteration sequence, matching the controller: ADDSUB computes y±x1_n; ADD writes y and computes n+1; MULT writes n, toggles sigma and computes x1·x1_n; WB2 writes x1_n; ENDIT checks.
- Termination, on check_for_termination_i with done=0: terminate if |x1_n|<EPS, n>N_MAX, or err_o. On terminate:
  - next cycle valid_o=1 for exactly one cycle.
  - result_o←(err_o ? 0 : y); iter_o←n; done←1.
- While done=1: all write enables and checks are ignored. The controller takes 2 further cycles to reach IDLE and still issues wren_y; that write must not corrupt state.
- Counter n saturates at 255.
- rst mid-run: everything clears; no valid_o pulse until a new start.

Decomposition:
- Package approx_pkg: ALU mode localparams (ADD_ONE..ALU_IDLE, shared with the controller), Q-format ONE constant, EPS/N_MAX defaults.
- Sub-module approx_alu: combinational operand muxes, operation select, saturation. The register file and termination logic stay in approx_datapath.

Test Plan:
- Run each scenario with the controller connected, start pulse at cycle 0.
- x=0x1000 (1.0): x1_n=0, so the first ENDIT terminates → valid_o single pulse, result_o=0x1000, iter_o=2, err_o=0.
- x=0x0800 (0.5): terminates when x1_n=2 LSB → result_o=0x1FFC, iter_o=11; y stays 0x1FFC after the controller's late wren_y.
- N_MAX=4, x=0x0800 → result_o=0x1F00, iter_o=5; exactly one valid_o pulse.
- x=0x2400 (2.25) → err_o=1, valid_o at the first ENDIT, result_o=0, iter_o=2.
- x=0x0800, rst asserted during the 3rd iteration, then start with x=0x1000 → no valid_o before restart, then result_o=0x1000.
- start_i asserted in the same cycle as wren_y_i → y=0x1000, n=1, sigma=1 after that edge.
